// File: rtl/sar_cmp_responder_if.sv
// rtl/sar_cmp_responder_if.sv - SAR controller <-> comparator responder handshake bundle
interface sar_cmp_responder_if #(
    parameter int Width = 6
) ();
    logic             sample;
    logic [Width-1:0] dac;
    logic             eoc;
    logic [Width-1:0] result;
    logic             cmp;

    modport master (
        output sample,
        output dac,
        output eoc,
        output result,
        input  cmp
    );

    modport slave (
        input  sample,
        input  dac,
        input  eoc,
        input  result,
        output cmp
    );
endinterface

// File: rtl/sar_cmp_responder.sv
// rtl/sar_cmp_responder.sv - emulated sample/hold + comparator answering a SAR controller, with result checking
module sar_cmp_responder #(
    parameter int Width      = 6,
    parameter int CmpLatency = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [Width-1:0]   vin_i,
    input  logic [2:0]         offset_i,
    sar_cmp_responder_if.slave sar,
    output logic [Width-1:0]   held_o,
    output logic               pass_o,
    output logic               fail_o,
    output logic               err_o,
    output logic [7:0]         conv_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        CONV  = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             sample_q;
    logic             track_en;
    logic             do_check;
    logic             do_err;
    logic             raw_cmp;
    logic [Width-1:0] tracked;

    // Two extra bits so both underflow (sign) and overflow (bit Width) are visible.
    logic signed [Width+1:0] sum;

    assign sum = $signed({2'b00, vin_i}) + $signed({{(Width-1){offset_i[2]}}, offset_i});
    assign tracked = sum[Width+1] ? '0 :
                     sum[Width]   ? '1 : sum[Width-1:0];

    assign raw_cmp = (sar.dac <= held_o);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-cycle control decisions
    always_comb begin
        state_d  = state_q;
        track_en = 1'b0;
        do_check = 1'b0;
        do_err   = 1'b0;
        case (state_q)
            IDLE: begin
                track_en = sar.sample;
                do_err   = sar.eoc;
                if (sar.sample) begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                track_en = sar.sample;
                do_err   = sar.eoc;
                if (sample_q && !sar.sample) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                // eoc takes priority over a re-sample request in the same cycle
                if (sar.eoc) begin
                    do_check = 1'b1;
                    state_d  = CHECK;
                end else if (sar.sample) begin
                    do_err   = 1'b1;
                    track_en = 1'b1;
                    state_d  = TRACK;
                end
            end
            CHECK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sample edge detector and the tracking hold register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q <= 1'b0;
            held_o   <= '0;
        end else begin
            sample_q <= sar.sample;
            if (track_en) begin
                held_o <= tracked;
            end
        end
    end

    // Result check pulses and conversion counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pass_o     <= 1'b0;
            fail_o     <= 1'b0;
            conv_cnt_o <= '0;
        end else begin
            pass_o <= do_check && (sar.result == held_o);
            fail_o <= do_check && (sar.result != held_o);
            if (do_check) begin
                conv_cnt_o <= conv_cnt_o + 8'd1;
            end
        end
    end

    // Sticky protocol error flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_o <= 1'b0;
        end else if (do_err) begin
            err_o <= 1'b1;
        end
    end

    generate
        if (CmpLatency == 0) begin : g_cmp_direct
            assign sar.cmp = raw_cmp;
        end else begin : g_cmp_delay
            logic [CmpLatency-1:0] dly_q;

            // Comparator decision delay line; shifts every cycle regardless of state
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= (dly_q << 1) | CmpLatency'(raw_cmp);
                end
            end

            assign sar.cmp = dly_q[CmpLatency-1];
        end
    endgenerate

endmodule

// File: tb/tb_sar_cmp_responder.sv
// tb/tb_sar_cmp_responder.sv - randomized closed-loop bench for sar_cmp_responder
module tb_sar_cmp_responder;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] vin = '0;
    logic [2:0]   offset = '0;
    logic         sample = 1'b0;
    logic [W-1:0] dac = '1;
    logic         eoc = 1'b0;
    logic [W-1:0] result = '0;

    logic [W-1:0] held0, held2;
    logic         pass0, fail0, err0, pass2, fail2, err2;
    logic [7:0]   cnt0, cnt2;

    int n_checks = 0;
    int n_ok = 0;

    int exp_held = 0;
    int exp_cnt = 0;
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    sar_cmp_responder_if #(.Width(W)) if0 ();
    sar_cmp_responder_if #(.Width(W)) if2 ();

    assign if0.sample = sample;
    assign if0.dac    = dac;
    assign if0.eoc    = eoc;
    assign if0.result = result;
    assign if2.sample = sample;
    assign if2.dac    = dac;
    assign if2.eoc    = eoc;
    assign if2.result = result;

    sar_cmp_responder #(.Width(W), .CmpLatency(0)) dut0 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .vin_i      (vin),
        .offset_i   (offset),
        .sar        (if0),
        .held_o     (held0),
        .pass_o     (pass0),
        .fail_o     (fail0),
        .err_o      (err0),
        .conv_cnt_o (cnt0)
    );

    sar_cmp_responder #(.Width(W), .CmpLatency(2)) dut2 (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .vin_i      (vin),
        .offset_i   (offset),
        .sar        (if2),
        .held_o     (held2),
        .pass_o     (pass2),
        .fail_o     (fail2),
        .err_o      (err2),
        .conv_cnt_o (cnt2)
    );

    function automatic int sat(input int v, input int off);
        int s;
        s = v + off;
        if (s < 0) s = 0;
        if (s > (1 << W) - 1) s = (1 << W) - 1;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        sample = 1'b0;
        eoc = 1'b0;
        dac = '1;
        tick();
        tick();
        rst_n = 1'b1;
        exp_held = 0;
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    // Track vin+off for two cycles, then drop sample so the responder enters CONV.
    task automatic track(input int v, input int off);
        vin = v[W-1:0];
        offset = off[2:0];
        sample = 1'b1;
        tick();
        tick();
        sample = 1'b0;
        tick();
        exp_held = sat(v, off);
        @(negedge clk);
        n_checks++;
        if (held0 !== exp_held[W-1:0]) $display("FAIL held_after_track: got %0d want %0d", held0, exp_held);
        else n_ok++;
    endtask

    // Run the binary search against dut0's comparator, then pulse eoc and check the verdict.
    task automatic finish(input bit force_res, input int force_val);
        int code;
        int trial;
        bit exp_pass;
        code = 0;
        tick();
        for (int i = W - 1; i >= 0; i--) begin
            trial = code | (1 << i);
            dac = trial[W-1:0];
            @(negedge clk);
            n_checks++;
            if (if0.cmp !== (trial <= exp_held)) $display("FAIL sar_cmp trial=%0d: got %0b want %0b", trial, if0.cmp, trial <= exp_held);
            else n_ok++;
            if (if0.cmp) code = trial;
            tick();
        end
        n_checks++;
        if (code != exp_held) $display("FAIL sar_code: got %0d want %0d", code, exp_held);
        else n_ok++;
        result = force_res ? force_val[W-1:0] : code[W-1:0];
        exp_pass = (result == exp_held[W-1:0]);
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        @(negedge clk);
        n_checks++;
        if ({pass0, fail0} !== {exp_pass, !exp_pass}) $display("FAIL check_pulse: got pass=%0b fail=%0b want pass=%0b", pass0, fail0, exp_pass);
        else n_ok++;
        n_checks++;
        if (cnt0 !== exp_cnt[7:0] || err0 !== exp_err) $display("FAIL cnt_err: got cnt=%0d err=%0b want cnt=%0d err=%0b", cnt0, err0, exp_cnt, exp_err);
        else n_ok++;
        tick();
        @(negedge clk);
        n_checks++;
        if ({pass0, fail0} !== 2'b00) $display("FAIL pulse_width: got pass=%0b fail=%0b want 0 0", pass0, fail0);
        else n_ok++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        dac = '1;
        #2;
        @(negedge clk);
        n_checks++;
        if ({held0, pass0, fail0, err0, cnt0, if0.cmp} !== '0) $display("FAIL reset_dut0: got held=%0d pass=%0b fail=%0b err=%0b cnt=%0d cmp=%0b want all 0", held0, pass0, fail0, err0, cnt0, if0.cmp);
        else n_ok++;
        n_checks++;
        if ({held2, pass2, fail2, err2, cnt2, if2.cmp} !== '0) $display("FAIL reset_dut2: got held=%0d cnt=%0d cmp=%0b want all 0", held2, cnt2, if2.cmp);
        else n_ok++;
        apply_reset();
    endtask

    task automatic test_closed_loop();
        int v, off;
        track(45, 0);  finish(1'b0, 0);
        track(10, -3); finish(1'b0, 0);
        track(62, 3);  finish(1'b0, 0);
        track(2, -4);  finish(1'b0, 0);
        for (int n = 0; n < 20; n++) begin
            v = $urandom_range(0, (1 << W) - 1);
            off = int'($urandom_range(0, 7)) - 4;
            track(v, off);
            finish(1'b0, 0);
        end
    endtask

    task automatic test_fail();
        track(45, 0);
        finish(1'b1, 44);
    endtask

    task automatic test_latency();
        int hist[$];
        int seq[$];
        int d;
        bit exp;
        track(40, 0);
        for (int i = 0; i < 3; i++) begin
            dac = 6'd63;
            hist.push_back(0);
            tick();
        end
        seq = '{32, 16, 48};
        for (int i = 0; i < 12; i++) seq.push_back($urandom_range(0, (1 << W) - 1));
        foreach (seq[i]) begin
            d = seq[i];
            dac = d[W-1:0];
            @(negedge clk);
            exp = hist[hist.size() - 2][0];
            n_checks++;
            if (if2.cmp !== exp) $display("FAIL cmp_latency2 step=%0d: got %0b want %0b", i, if2.cmp, exp);
            else n_ok++;
            hist.push_back(d <= exp_held ? 1 : 0);
            tick();
        end
        finish(1'b0, 0);
    endtask

    task automatic test_simultaneous();
        apply_reset();
        track(33, 1);
        result = 6'd34;
        vin = 6'd12;
        offset = 3'd0;
        eoc = 1'b1;
        sample = 1'b1;
        tick();
        eoc = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        @(negedge clk);
        n_checks++;
        if ({pass0, fail0, err0} !== 3'b100 || cnt0 !== exp_cnt[7:0]) $display("FAIL simul_check: got pass=%0b fail=%0b err=%0b cnt=%0d want 1 0 0 %0d", pass0, fail0, err0, cnt0, exp_cnt);
        else n_ok++;
        n_checks++;
        if (held0 !== 6'd34) $display("FAIL simul_held_check: got %0d want 34", held0);
        else n_ok++;
        tick();
        @(negedge clk);
        n_checks++;
        if (held0 !== 6'd34 || pass0 !== 1'b0) $display("FAIL simul_idle: got held=%0d pass=%0b want 34 0", held0, pass0);
        else n_ok++;
        tick();
        @(negedge clk);
        n_checks++;
        if (held0 !== 6'd12) $display("FAIL simul_retrack: got %0d want 12", held0);
        else n_ok++;
        sample = 1'b0;
        tick();
        exp_held = 12;
        finish(1'b0, 0);
    endtask

    task automatic test_protocol_errors();
        int cnt_before;
        cnt_before = exp_cnt;
        eoc = 1'b1;
        result = 6'd0;
        tick();
        eoc = 1'b0;
        exp_err = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({err0, pass0, fail0} !== 3'b100 || cnt0 !== cnt_before[7:0]) $display("FAIL eoc_in_idle: got err=%0b pass=%0b fail=%0b cnt=%0d want 1 0 0 %0d", err0, pass0, fail0, cnt0, cnt_before);
        else n_ok++;
        repeat (3) tick();
        n_checks++;
        if (err0 !== 1'b1) $display("FAIL err_sticky: got %0b want 1", err0);
        else n_ok++;
        track(20, 0);
        vin = 6'd30;
        sample = 1'b1;
        tick();
        sample = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pass0, fail0} !== 2'b00 || held0 !== 6'd30 || cnt0 !== cnt_before[7:0]) $display("FAIL sample_in_conv: got pass=%0b fail=%0b held=%0d cnt=%0d want 0 0 30 %0d", pass0, fail0, held0, cnt0, cnt_before);
        else n_ok++;
        tick();
        exp_held = 30;
        finish(1'b0, 0);
    endtask

    task automatic test_wrap();
        int v, off;
        apply_reset();
        for (int n = 0; n < 256; n++) begin
            v = $urandom_range(0, (1 << W) - 1);
            off = int'($urandom_range(0, 7)) - 4;
            track(v, off);
            finish(1'b0, 0);
        end
        n_checks++;
        if (cnt0 !== 8'd0) $display("FAIL cnt_wrap: got %0d want 0", cnt0);
        else n_ok++;
    endtask

    task automatic test_reset_mid_conv();
        track(50, 0);
        finish(1'b0, 0);
        track(50, 0);
        dac = 6'd63;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({held0, pass0, fail0, err0, cnt0, if0.cmp, if2.cmp} !== '0) $display("FAIL reset_mid_conv: got held=%0d cnt=%0d err=%0b cmp0=%0b cmp2=%0b want all 0", held0, cnt0, err0, if0.cmp, if2.cmp);
        else n_ok++;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        eoc = 1'b1;
        result = 6'd0;
        tick();
        eoc = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({err0, pass0, fail0} !== 3'b100 || cnt0 !== 8'd0) $display("FAIL idle_after_reset: got err=%0b pass=%0b fail=%0b cnt=%0d want 1 0 0 0", err0, pass0, fail0, cnt0);
        else n_ok++;
    endtask

    initial begin
        test_reset();
        test_closed_loop();
        test_fail();
        test_latency();
        test_simultaneous();
        test_protocol_errors();
        test_wrap();
        test_reset_mid_conv();
        $display("%0d/%0d checks passed", n_ok, n_checks);
        $finish;
    end

endmodule

// File: doc/sar_cmp_responder.md
Name: sar_cmp_responder

Overview:
- Digital responder for the SAR binary-search controller: it plays the analog side (sample-and-hold, comparator) that answers the controller's sample/DAC/end-of-conversion outputs.
- Holds a target code, returns the comparator decision with programmable latency, and checks each finished conversion against the held code.
- Used on-chip for self-test and in benches as the closed-loop partner of the SAR FSM.

Parameters:
- Width, 6, code width; must match the SAR controller.
- CmpLatency, 1, comparator decision delay in clk_i cycles, legal range 0..3.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- vin_i  in  Width  emulated analog input code, tracked while sampling.
- offset_i  in  3  signed comparator offset (-4..+3 LSB) added to the held code.
- sample_i  in  1  sample/track request from the SAR controller.
- dac_i  in  Width  current DAC trial code from the SAR controller.
- eoc_i  in  1  end-of-conversion pulse from the SAR controller.
- result_i  in  Width  final SAR result, valid while eoc_i=1.
- cmp_o  out  1  comparator decision: 1 = dac_i <= held code (keep bit).
- held_o  out  Width  held (offset-corrected) code.
- pass_o  out  1  one-cycle pulse: result matched held code.
- fail_o  out  1  one-cycle pulse: result mismatched held code.
- err_o  out  1  sticky protocol-error flag.
- conv_cnt_o  out  8  number of checked conversions.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; held_o=0; cmp_o=0; delay line=0.
  - pass_o=0, fail_o=0, err_o=0, conv_cnt_o=0.
- Sampling and hold:
  - sample_i is registered internally to detect edges.
  - Each cycle sample_i=1, held_o follows sat(vin_i + sign-extended offset_i), registered.
  - Saturation range is 0..2^Width-1 (e.g. vin 2, offset -4 -> 0; vin 62, offset +3 -> 63).
  - On the cycle sample_i falls, the last tracked value is frozen in held_o.
- Comparator:
  - raw = (dac_i <= held_o).
  - CmpLatency=0: cmp_o = raw, combinational.
  - CmpLatency=N: raw passes through N registers, so cmp_o equals raw from N cycles earlier.
  - The delay line keeps shifting in every state; it is cleared only by reset.
- FSM:
  - IDLE -> TRACK on sample_i=1.
  - TRACK -> CONV on sample_i falling edge.
  - CONV -> CHECK on eoc_i=1.
  - CHECK -> IDLE unconditionally, after one cycle.
- Check (registered in the CONV->CHECK transition cycle, pulses visible during CHECK):
  - result_i == held_o: pass_o=1.
  - otherwise: fail_o=1.
  - conv_cnt_o increments by 1, wrapping 255 -> 0.
- Protocol errors (err_o set, sticky until reset):
  - eoc_i=1 in IDLE or TRACK: counter unchanged, no pass/fail pulse.
  - sample_i=1 in CONV: enter TRACK, conversion abandoned, no pass/fail pulse.
- Simultaneous events:
  - eoc_i=1 and sample_i=1 in CONV: eoc wins; the check is performed and err_o is not set.
  - CHECK -> IDLE, then the still-high sample_i moves the FSM to TRACK on the next cycle.
- held_o changes only while tracking, so it is stable throughout CONV and CHECK.
- Reset asserted mid-conversion: all outputs return to reset values immediately; the FSM restarts in IDLE.

Test Plan:
- Closed loop with the SAR FSM (Width=6), CmpLatency=0, vin_i=45, offset_i=0 -> held_o=45, result 45, pass_o pulse, conv_cnt_o=1, err_o=0.
- vin_i=10, offset_i=-3 (3'b101) -> held_o=7, SAR result 7, pass_o; vin_i=62, offset_i=+3 -> held_o=63 (saturated), pass_o.
- CmpLatency=2, dac_i stepping 32, 16, 48 with held_o=40 -> cmp_o sequence 1, 1, 0, each appearing exactly 2 cycles after the matching dac_i.
- Force result_i=44 with held_o=45 at eoc_i -> fail_o one-cycle pulse, pass_o=0, conv_cnt_o still increments.
- eoc_i pulse in IDLE -> err_o=1 and stays 1, conv_cnt_o unchanged; sample_i raised mid-CONV -> FSM in TRACK, no pass/fail pulse.
- 256 back-to-back passing conversions -> conv_cnt_o wraps to 0; rst_ni pulsed low mid-CONV -> all outputs 0 in the same cycle, FSM in IDLE.
